// File: rtl/attn_dot_engine.sv
// attn_dot_engine: streaming Q.K dot-product engine for the attention path.
// Operands arrive interleaved (Q first, then K). FEATURES products are summed
// per score. Each score is scaled by an arithmetic right shift, reduced to
// OUT_W bits and queued in a small output FIFO that carries a row-end marker.
// Optional feature macro: ATTN_SCORE_SAT_EN. When it is defined, the output
// reduction saturates. When it is undefined, the output reduction truncates
// (two's-complement wrap).
module attn_dot_engine #(
  parameter int DATA_W     = 8,
  parameter int FEATURES   = 4,
  parameter int ROW_LEN    = 4,
  parameter int SHIFT      = 8,
  parameter int OUT_W      = 9,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_last,
  output logic              busy
);

  localparam int ACC_W  = 2*DATA_W + $clog2(FEATURES);
  localparam int CNT_W  = (FEATURES > 1)   ? $clog2(FEATURES)   : 1;
  localparam int ROW_W  = (ROW_LEN > 1)    ? $clog2(ROW_LEN)    : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {GET_Q, GET_K, EMIT} state_t;

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_q;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_pair_cnt;
  logic [ROW_W-1:0]         r_row_cnt;

  logic [OUT_W:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [FCNT_W-1:0]        r_cnt;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_shift;
  logic [OUT_W-1:0]           w_score;
  logic                       w_last;
  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;

  // Full-precision signed product. Both operands are signed, so the product
  // is sign-correct at 2*DATA_W bits.
  assign w_prod  = r_q * $signed(in_data);
  assign w_shift = r_acc >>> SHIFT;
  assign w_last  = (r_row_cnt == ROW_W'(ROW_LEN - 1));

`ifdef ATTN_SCORE_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  // Clamp the scaled accumulator to the signed OUT_W range.
  always_comb begin
    w_score = w_shift[OUT_W-1:0];
    if (w_shift > SMAX)      w_score = SMAX[OUT_W-1:0];
    else if (w_shift < SMIN) w_score = SMIN[OUT_W-1:0];
  end
`else
  logic w_unused_hi;
  // Keep only the low OUT_W bits. The upper bits are discarded on purpose.
  assign w_score     = w_shift[OUT_W-1:0];
  assign w_unused_hi = ^w_shift[ACC_W-1:OUT_W];
`endif

  assign w_full  = (r_cnt == FCNT_W'(FIFO_DEPTH));
  assign out_vld = (r_cnt != '0);
  assign w_pop   = out_vld && out_rdy;
  // A full FIFO blocks the push even when the head pops in the same cycle.
  assign w_push  = (r_state == EMIT) && !w_full;

  assign in_rdy   = (r_state != EMIT);
  assign busy     = (r_state != GET_Q) || (r_pair_cnt != '0);
  assign out_data = out_vld ? r_mem[r_rd_ptr][OUT_W-1:0] : '0;
  assign out_last = out_vld && r_mem[r_rd_ptr][OUT_W];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Operand FSM: collect Q/K pairs, accumulate, then emit one score.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= GET_Q;
      r_q        <= '0;
      r_acc      <= '0;
      r_pair_cnt <= '0;
      r_row_cnt  <= '0;
    end else begin
      case (r_state)
        GET_Q: if (in_vld) begin
          r_q     <= $signed(in_data);
          r_state <= GET_K;
        end
        GET_K: if (in_vld) begin
          r_acc      <= r_acc + ACC_W'(w_prod);
          r_pair_cnt <= r_pair_cnt + 1'b1;
          r_state    <= (r_pair_cnt == CNT_W'(FEATURES - 1)) ? EMIT : GET_Q;
        end
        EMIT: if (!w_full) begin
          r_acc      <= '0;
          r_pair_cnt <= '0;
          r_row_cnt  <= w_last ? '0 : r_row_cnt + 1'b1;
          r_state    <= GET_Q;
        end
        default: r_state <= GET_Q;
      endcase
    end
  end

  // FIFO pointers and occupancy. Reset discards all entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= r_cnt + FCNT_W'(w_push) - FCNT_W'(w_pop);
    end
  end

  // FIFO storage {last, score}. Contents are masked by out_vld, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_last, w_score};
  end

endmodule

// File: tb/tb_attn_dot_engine.sv
// Self-checking bench for attn_dot_engine (default parameters).
// Reference model: integer dot product, then shift, then reduction, queued per score.
module tb_attn_dot_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic [8:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;
  logic       busy;

  logic rdy_force;
  logic rnd_rdy;
  logic rnd_bit;

  int n_vec = 0;
  int n_err = 0;
  int n_last = 0;

  // reference model state
  logic [9:0] exp_q[$];
  int m_beat, m_acc, m_q, m_scores;

`ifdef ATTN_SCORE_SAT_EN
  localparam logic [8:0] OVF_EXP = 9'h0FF;
`else
  localparam logic [8:0] OVF_EXP = 9'h100;
`endif

  attn_dot_engine dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  assign out_rdy = rnd_rdy ? rnd_bit : rdy_force;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [8:0] ref_score(input int acc);
    int s;
    s = acc >>> 8;
`ifdef ATTN_SCORE_SAT_EN
    if (s > 255) s = 255;
    else if (s < -256) s = -256;
`endif
    return 9'(s);
  endfunction

  task automatic model_beat(input logic [7:0] d);
    logic signed [7:0] sd;
    sd = d;
    if (m_beat % 2 == 0) m_q = sd;
    else m_acc += m_q * int'(sd);
    m_beat++;
    if (m_beat == 8) begin
      exp_q.push_back({(m_scores % 4) == 3, ref_score(m_acc)});
      m_scores++;
      m_beat = 0;
      m_acc  = 0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_beat = 0; m_acc = 0; m_q = 0; m_scores = 0;
  endtask

  // present one beat; returns at #1 after the accepting edge with in_vld still high
  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    in_data = d;
    in_vld  = 1'b1;
    @(negedge clk);
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      chk("in_timeout", 32'(in_rdy), 1);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk); #1;
    model_beat(d);
  endtask

  task automatic send_pairs(input logic [7:0] q, input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(q);
      send_beat(k);
    end
    in_vld = 1'b0;
  endtask

  task automatic send_rand_score(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_vld  = 1'b0;
        in_data = 8'($urandom);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_beat(8'($urandom));
    end
    in_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    rnd_rdy   = 1'b0;
    rdy_force = 1'b1;
    while ((out_vld || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  // output monitor: scoreboard on pop, hold checks while stalled
  logic       stall_prev = 1'b0;
  logic [8:0] hold_data;
  logic       hold_last;
  logic [9:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld", 32'(out_vld), 1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
        chk("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_vld), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_e[8:0]));
          chk("out_last", 32'(out_last), 32'(mon_e[9]));
          if (out_last) n_last++;
        end
      end
      stall_prev = out_vld && !out_rdy;
      hold_data  = out_data;
      hold_last  = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0;
    rdy_force = 1'b0; rnd_rdy = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_in_rdy",   32'(in_rdy),   1);
    chk("rst_out_vld",  32'(out_vld),  0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy",     32'(busy),     0);
    rst_n = 1'b1;
    rdy_force = 1'b1;

    // basic score and one-edge latency
    send_pairs(8'h40, 8'h40, 4);
    chk("basic_pre_vld", 32'(out_vld), 0);
    chk("basic_emit_busy", 32'(busy), 1);
    chk("basic_emit_rdy", 32'(in_rdy), 0);
    @(posedge clk); #1;
    chk("basic_vld",  32'(out_vld),  1);
    chk("basic_data", 32'(out_data), 32'h040);
    chk("basic_last", 32'(out_last), 0);
    wait_drain();

    // negative score
    send_pairs(8'h40, 8'hC0, 4);
    @(posedge clk); #1;
    chk("neg_data", 32'(out_data), 32'h1C0);
    wait_drain();

    // overflow reduction
    send_pairs(8'h80, 8'h80, 4);
    @(posedge clk); #1;
    chk("ovf_data", 32'(out_data), 32'(OVF_EXP));
    wait_drain();

    // backpressure: two scores fill the FIFO, the third stalls in EMIT
    rdy_force = 1'b0;
    for (int i = 0; i < 3; i++) send_rand_score(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_in_rdy", 32'(in_rdy),  0);
    chk("bp_busy",   32'(busy),    1);
    chk("bp_vld",    32'(out_vld), 1);
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    chk("bp_blocked", 32'(in_rdy), 0);
    @(posedge clk); #1;
    chk("bp_landed", 32'(in_rdy), 1);
    chk("bp_idle",   32'(busy),   0);
    repeat (3) @(posedge clk);
    #1;
    wait_drain();

    // row marker across a wrap
    do_reset();
    n_last = 0;
    for (int i = 0; i < 9; i++) send_rand_score(1'b0);
    wait_drain();
    chk("row_last_count", 32'(n_last), 2);

    // reset in the middle of a score
    for (int i = 0; i < 5; i++) send_beat(8'($urandom));
    in_vld = 1'b0;
    do_reset();
    chk("rst_mid_vld",  32'(out_vld), 0);
    chk("rst_mid_busy", 32'(busy),    0);
    send_pairs(8'h40, 8'h40, 4);
    @(posedge clk); #1;
    chk("rst_next_data", 32'(out_data), 32'h040);
    chk("rst_next_last", 32'(out_last), 0);
    wait_drain();

    // randomized operands, input gaps and output backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send_rand_score(1'b1);
    wait_drain();
    chk("end_vld", 32'(out_vld), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/attn_dot_engine.md
# attn_dot_engine

Parametrised streaming dot-product engine for the attention datapath. It accepts interleaved Q/K operand elements on a valid/ready slave port and accumulates FEATURES signed products per score. Each finished score is scaled, reduced to OUT_W bits and buffered in a small output FIFO. The FIFO drains over a valid/ready master port with full backpressure and a row-end marker, and feeds the downstream exp/softmax stage.

## Interface
- DATA_W, 8: operand width, signed Q0.(DATA_W-1).
- FEATURES, 4: products per score; ≥1.
- ROW_LEN, 4: scores per row, used for out_last; ≥1.
- SHIFT, 8: arithmetic right shift applied to the accumulator before output reduction.
- OUT_W, 9: output score width, signed.
- FIFO_DEPTH, 2: output FIFO entries; ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_data  in  DATA_W  operand element; Q and K alternate, Q first.
- in_vld  in  1  slave valid.
- in_rdy  out  1  slave ready.
- out_data  out  OUT_W  score at FIFO head.
- out_vld  out  1  master valid; FIFO non-empty.
- out_rdy  in  1  master ready.
- out_last  out  1  head score is the last of its row.
- busy  out  1  high when the accumulator holds a partial or unemitted score.

## Operation
- Accumulator: signed, ACC_W = 2·DATA_W + clog2(FEATURES) bits; no overflow is possible by construction.
- State machine with states GET_Q, GET_K and EMIT; reset state is GET_Q.
- GET_Q:
  - in_rdy=1.
  - On in_vld: latch in_data as q, go to GET_K.
- GET_K:
  - in_rdy=1.
  - On in_vld: acc += q·in_data (full-precision signed product), increment pair_cnt.
  - If pair_cnt was FEATURES-1, go to EMIT; otherwise go to GET_Q.
  - There is no idle cycle between pairs.
- EMIT:
  - in_rdy=0.
  - If the FIFO is not full: push {score, last}, clear acc and pair_cnt, advance row_cnt, go to GET_Q.
  - If the FIFO is full: hold all state; in_rdy stays 0.
- Push rule: a full FIFO blocks the push even if a pop happens in the same cycle.
- Score computation: s = acc >>> SHIFT (arithmetic shift), then reduce to OUT_W bits (see Configuration).
- last = (row_cnt == ROW_LEN-1). row_cnt wraps to 0 after ROW_LEN pushes.
- FIFO:
  - Pop when out_vld && out_rdy.
  - Push and pop in the same cycle are both honoured when not full.
  - out_data and out_last reflect the head entry; both are 0 when the FIFO is empty.
- busy = (state != GET_Q) || (pair_cnt != 0).
- Reset mid-operation: the partial accumulator, any latched q, the counters and all FIFO contents are discarded.

## Timing
- Values after the first clock edge with rst_n=0:
  - in_rdy=1, out_vld=0, out_data=0, out_last=0, busy=0.
  - acc=0, pair_cnt=0, row_cnt=0, FIFO empty.
- Minimum input cost: 2·FEATURES accepted beats plus 1 EMIT cycle per score.
- Peak rate: one score per 2·FEATURES+1 cycles.
- Latency, no backpressure:
  - Last K accepted at edge N.
  - EMIT during cycle N→N+1; push at edge N+1.
  - out_vld=1 from edge N+1, with data valid in the same cycle.
- in_vld low in GET_Q or GET_K: state holds and nothing accumulates.
- in_data is sampled only when in_vld && in_rdy.
- out_vld never drops without a pop.
- out_data and out_last stay stable while out_vld && !out_rdy.

## Configuration
- Macro ATTN_SCORE_SAT_EN selects the output reduction.
- Defined: s is saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: s is truncated to its low OUT_W bits (two's-complement wrap).
- The macro changes only the output reduction; handshake timing is identical in both builds.

## Test plan
All scenarios use default parameters.
- Basic score: 4 pairs Q=K=0x40 with in_vld always high → one score 0x040 (+1.0 in Q.6); out_vld rises 1 edge after the 4th K; out_last=0.
- Negative score: 4 pairs Q=0x40, K=0xC0 → 0x1C0 (−64).
- Overflow:
  - Stimulus: 4 pairs Q=K=0x80 (acc=65536, s=256).
  - Without ATTN_SCORE_SAT_EN: out_data=0x100.
  - With ATTN_SCORE_SAT_EN: out_data=0x0FF.
- Backpressure:
  - Stimulus: out_rdy=0, 3 scores streamed.
  - First 2 scores fill the FIFO.
  - The engine stalls in EMIT with in_rdy=0 and busy=1.
  - Releasing out_rdy for one cycle lets the third push land on the next edge.
  - Scores emerge in order with stable data.
- Row marker:
  - Stimulus: 9 scores streamed with out_rdy=1.
  - out_last=1 on scores 4 and 8 only.
  - Score 9 has out_last=0, confirming row_cnt wrap.
- Reset:
  - Stimulus: rst_n pulsed low after 5 accepted beats (mid-score), then 4 fresh pairs Q=K=0x40.
  - No output from the aborted score.
  - The next score is 0x040 with out_last=0.
